// File: rtl/touch_scan.sv
// Resistive touch-panel front end: pen-down detect, serial X/Y conversions with
// CS held low per report, per-axis averaging and a one-cycle coordinate strobe.
module touch_scan #(
  parameter int CLK_DIV    = 25,
  parameter int RES_BITS   = 12,
  parameter int AVG_LOG2   = 2,
  parameter int GAP_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                interrupt,
  input  logic                DOUT,
  output logic                TP_CS,
  output logic                TP_DCLK,
  output logic                DIN,
  output logic                lcdoff,
  output logic                touching,
  output logic                valid,
  output logic [RES_BITS-1:0] xaxis,
  output logic [RES_BITS-1:0] yaxis
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int ACC_W = RES_BITS + AVG_LOG2;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int FR_W  = AVG_LOG2 + 1;

  localparam logic             MODE      = (RES_BITS == 8);
  localparam logic [7:0]       CMD_X     = {4'b1101, MODE, 3'b000};
  localparam logic [7:0]       CMD_Y     = {4'b1001, MODE, 3'b000};
  localparam logic [4:0]       CAP_FIRST = 5'd10;
  localparam logic [4:0]       CAP_LAST  = 5'(9 + RES_BITS);
  localparam logic [DIV_W-1:0] DIV_END   = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_END   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [FR_W-1:0]  FR_LAST   = FR_W'(2 * N - 1);
  localparam logic [FR_W-1:0]  FR_Y      = FR_W'(N);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_DONE, S_GAP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_irq_s1, r_irq_s2;
  logic [DIV_W-1:0]    r_div;
  logic [4:0]          r_period;
  logic [FR_W-1:0]     r_frame;
  logic                r_fin;
  logic [GAP_W-1:0]    r_gap;
  logic                r_dclk, r_din, r_touch, r_valid;
  logic [RES_BITS-1:0] r_sr;
  logic [ACC_W-1:0]    r_acc_x, r_acc_y;

  logic       w_div_end, w_step, w_rise, w_fall, w_last, w_is_x, w_start;
  logic [7:0] w_cmd;
  logic [2:0] w_bit_sel;

  function automatic logic [RES_BITS-1:0] avg_of(input logic [ACC_W-1:0] acc);
    return acc[ACC_W-1:AVG_LOG2];
  endfunction

  assign w_div_end = (r_div == DIV_END);
  assign w_step    = (r_state == S_SHIFT) && !r_fin && w_div_end;
  assign w_rise    = w_step && !r_dclk;
  assign w_fall    = w_step && r_dclk;
  assign w_last    = (r_frame == FR_LAST);
  assign w_is_x    = (r_frame < FR_Y);
  assign w_cmd     = w_is_x ? CMD_X : CMD_Y;
  assign w_bit_sel = 3'd7 - r_period[2:0];
  assign w_start   = (r_state != S_SETUP) && (w_next == S_SETUP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // interrupt is only consulted in IDLE and at the end of GAP
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!r_irq_s2) w_next = S_SETUP;
      S_SETUP: if (w_div_end) w_next = S_SHIFT;
      S_SHIFT: if (r_fin) w_next = S_DONE;
      S_DONE:  w_next = S_GAP;
      S_GAP:   if (r_gap == GAP_END) w_next = r_irq_s2 ? S_IDLE : S_SETUP;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_s1 <= 1'b1;
      r_irq_s2 <= 1'b1;
      r_div    <= '0;
      r_period <= 5'd1;
      r_frame  <= '0;
      r_fin    <= 1'b0;
      r_gap    <= '0;
      r_dclk   <= 1'b0;
      r_din    <= 1'b0;
      r_touch  <= 1'b0;
      r_valid  <= 1'b0;
      r_sr     <= '0;
      r_acc_x  <= '0;
      r_acc_y  <= '0;
      xaxis    <= '0;
      yaxis    <= '0;
    end else begin
      r_irq_s1 <= interrupt;
      r_irq_s2 <= r_irq_s1;
      r_valid  <= 1'b0;
      if (w_start) begin
        r_div    <= '0;
        r_period <= 5'd1;
        r_frame  <= '0;
        r_fin    <= 1'b0;
        r_dclk   <= 1'b0;
        r_din    <= CMD_X[7];
        r_acc_x  <= '0;
        r_acc_y  <= '0;
        r_touch  <= 1'b1;
      end else if (r_state == S_SETUP || (r_state == S_SHIFT && !r_fin)) begin
        r_div <= w_div_end ? '0 : r_div + 1'b1;
        if (w_step) r_dclk <= !r_dclk;
        if (w_rise && r_period >= CAP_FIRST && r_period <= CAP_LAST)
          r_sr <= {r_sr[RES_BITS-2:0], DOUT};
        // DIN for the next period is launched on the falling edge closing this one
        if (w_fall) begin
          if (r_period < 5'd8)        r_din <= w_cmd[w_bit_sel];
          else if (r_period == 5'd24) r_din <= !w_last;
          else                        r_din <= 1'b0;
          if (r_period == 5'd24) begin
            r_period <= 5'd1;
            if (w_is_x) r_acc_x <= r_acc_x + ACC_W'(r_sr);
            else        r_acc_y <= r_acc_y + ACC_W'(r_sr);
            if (w_last) r_fin   <= 1'b1;
            else        r_frame <= r_frame + 1'b1;
          end else begin
            r_period <= r_period + 1'b1;
          end
        end
      end
      if (r_state == S_SHIFT && r_fin) begin
        xaxis   <= avg_of(r_acc_x);
        yaxis   <= avg_of(r_acc_y);
        r_valid <= 1'b1;
        r_fin   <= 1'b0;
      end
      if (r_state == S_DONE)     r_gap <= '0;
      else if (r_state == S_GAP) r_gap <= r_gap + 1'b1;
      if (r_state == S_GAP && w_next == S_IDLE) r_touch <= 1'b0;
    end
  end

  assign TP_CS    = !(r_state == S_SETUP || r_state == S_SHIFT);
  assign lcdoff   = !TP_CS;
  assign TP_DCLK  = r_dclk;
  assign DIN      = r_din;
  assign touching = r_touch;
  assign valid    = r_valid;

endmodule

// File: tb/tb_touch_scan.sv
// Bench for touch_scan: three configurations (12-bit single, 12-bit x4 average,
// 8-bit) each driven by a behavioural ADS7843-style controller model.
module tb_touch_scan;

  localparam int GAP = 8;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   irq [3];
  int     xs [3][4];
  int     ys [3][4];
  longint cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  logic [11:0] exp_x[$];
  logic [11:0] exp_y[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_m
    localparam int RES = (g == 2) ? 8 : 12;
    localparam int AVG = (g == 1) ? 2 : 0;
    logic cs, dclk, din, lcdoff, touching, valid, dout;
    logic [RES-1:0] xa, ya;
    logic [7:0] cmd_log [64];
    logic [7:0] cmd;
    logic [11:0] smp;
    logic prev_dclk, prev_cs;
    int pc, nx, ny, nb, ncmd, rises;
    longint last_rise, period, csfall;

    touch_scan #(.CLK_DIV(2), .RES_BITS(RES), .AVG_LOG2(AVG), .GAP_CYCLES(GAP)) u_dut (
      .clk(clk), .rst_n(rst_n), .interrupt(irq[g]), .DOUT(dout),
      .TP_CS(cs), .TP_DCLK(dclk), .DIN(din), .lcdoff(lcdoff),
      .touching(touching), .valid(valid), .xaxis(xa), .yaxis(ya));

    // Controller model: shifts the command in on DCLK rises, presents the
    // sample MSB first after falling edges so it is stable at rises 10..9+RES.
    initial begin
      dout = 1'b1; cmd = '0; smp = '0; prev_dclk = 1'b0; prev_cs = 1'b1;
      pc = 0; nx = 0; ny = 0; nb = 0; ncmd = 0; rises = 0;
      last_rise = 0; period = 0; csfall = 0;
      forever begin
        @(negedge clk);
        if (dclk && !prev_dclk) begin
          rises++;
          period = cyc - last_rise;
          last_rise = cyc;
        end
        if (!cs && prev_cs) csfall = cyc;
        if (cs) begin
          pc = 0; nx = 0; ny = 0; dout = 1'b1;
        end else if (dclk && !prev_dclk) begin
          pc++;
          if (pc <= 8) cmd = {cmd[6:0], din};
          if (pc == 8) begin cmd_log[ncmd % 64] = cmd; ncmd++; end
        end else if (!dclk && prev_dclk) begin
          if (pc == 24) begin
            pc = 0;
            if (cmd[6]) nx++; else ny++;
          end
          nb = pc + 1;
          smp = cmd[6] ? 12'(xs[g][nx % 4]) : 12'(ys[g][ny % 4]);
          if (nb >= 10 && nb <= 9 + RES) dout = smp[RES - 1 - (nb - 10)];
          else dout = 1'b1;
        end
        prev_dclk = dclk;
        prev_cs = cs;
      end
    end
  end

  task automatic test_reset();
    int r0, bad;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if ({g_m[0].cs, g_m[0].dclk, g_m[0].din, g_m[0].lcdoff} !== 4'b1000)
      $display("FAIL reset_bus: got cs/dclk/din/lcdoff=%b expected 1000", {g_m[0].cs, g_m[0].dclk, g_m[0].din, g_m[0].lcdoff}); else n_pass++;
    n_checks++; if ({g_m[0].touching, g_m[0].valid} !== 2'b00)
      $display("FAIL reset_status: got touching/valid=%b expected 00", {g_m[0].touching, g_m[0].valid}); else n_pass++;
    n_checks++; if ({g_m[0].xa, g_m[0].ya} !== 24'h0)
      $display("FAIL reset_axes: got %h expected 000000", {g_m[0].xa, g_m[0].ya}); else n_pass++;
    rst_n = 1'b1;
    r0 = g_m[0].rises;
    irq[0] = 1'b0;
    for (int i = 0; i < 500 && g_m[0].rises < r0 + 3; i++) begin @(negedge clk); #1; end
    n_checks++; if (g_m[0].rises < r0 + 3)
      $display("FAIL reset_reach_shift: got %0d rises expected >= 3", g_m[0].rises - r0); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({g_m[0].cs, g_m[0].dclk} !== 2'b10)
      $display("FAIL reset_midframe_bus: got cs/dclk=%b expected 10", {g_m[0].cs, g_m[0].dclk}); else n_pass++;
    n_checks++; if ({g_m[0].din, g_m[0].lcdoff, g_m[0].touching, g_m[0].valid} !== 4'b0000)
      $display("FAIL reset_midframe_out: got din/lcdoff/touching/valid=%b expected 0000", {g_m[0].din, g_m[0].lcdoff, g_m[0].touching, g_m[0].valid}); else n_pass++;
    irq[0] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (400) begin
      @(negedge clk); #1;
      if (g_m[0].valid || !g_m[0].cs) bad++;
    end
    n_checks++; if (bad !== 0)
      $display("FAIL reset_no_activity: got %0d active cycles expected 0", bad); else n_pass++;
  endtask

  task automatic test_single();
    logic [11:0] ex, ey;
    longint t_irq, t_v;
    int c0, nv;
    bit seen;
    exp_x.delete(); exp_y.delete();
    xs[0][0] = 'hA5C; ys[0][0] = 'h3F1;
    exp_x.push_back(12'hA5C); exp_y.push_back(12'h3F1);
    c0 = g_m[0].ncmd;
    @(negedge clk); #1;
    irq[0] = 1'b0;
    t_irq = cyc;
    seen = 0; t_v = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (g_m[0].valid) begin
        seen = 1; t_v = cyc;
        n_checks++; if ({g_m[0].cs, g_m[0].dclk} !== 2'b10)
          $display("FAIL single_done_bus: got cs/dclk=%b expected 10", {g_m[0].cs, g_m[0].dclk}); else n_pass++;
        ex = exp_x.pop_front(); ey = exp_y.pop_front();
        n_checks++; if (g_m[0].xa !== ex) $display("FAIL single_x: got %h expected %h", g_m[0].xa, ex); else n_pass++;
        n_checks++; if (g_m[0].ya !== ey) $display("FAIL single_y: got %h expected %h", g_m[0].ya, ey); else n_pass++;
        break;
      end
    end
    irq[0] = 1'b1;
    n_checks++; if (!seen) $display("FAIL single_valid: got no valid expected one within 1000 cycles"); else n_pass++;
    n_checks++; if (g_m[0].csfall - t_irq !== 3)
      $display("FAIL pendown_latency: got %0d expected 3", g_m[0].csfall - t_irq); else n_pass++;
    n_checks++; if (t_v - g_m[0].csfall !== 195)
      $display("FAIL single_latency: got %0d expected 195", t_v - g_m[0].csfall); else n_pass++;
    n_checks++; if (g_m[0].cmd_log[c0 % 64] !== 8'hD0)
      $display("FAIL single_cmd_x: got %h expected d0", g_m[0].cmd_log[c0 % 64]); else n_pass++;
    n_checks++; if (g_m[0].cmd_log[(c0 + 1) % 64] !== 8'h90)
      $display("FAIL single_cmd_y: got %h expected 90", g_m[0].cmd_log[(c0 + 1) % 64]); else n_pass++;
    n_checks++; if (g_m[0].period !== 4)
      $display("FAIL dclk_period: got %0d expected 4", g_m[0].period); else n_pass++;
    nv = 0;
    repeat (300) begin @(negedge clk); #1; if (g_m[0].valid) nv++; end
    n_checks++; if (nv !== 0) $display("FAIL single_extra_valid: got %0d expected 0", nv); else n_pass++;
    n_checks++; if (g_m[0].touching !== 1'b0)
      $display("FAIL single_penup: got touching=%b expected 0", g_m[0].touching); else n_pass++;
  endtask

  task automatic test_continuous();
    longint t [3];
    logic [11:0] ex, ey;
    int k, bad, bad_val;
    exp_x.delete(); exp_y.delete();
    xs[0][0] = 'h123; ys[0][0] = 'hEDC;
    for (int i = 0; i < 3; i++) begin exp_x.push_back(12'h123); exp_y.push_back(12'hEDC); end
    @(negedge clk); #1;
    irq[0] = 1'b0;
    k = 0; bad = 0; bad_val = 0;
    for (int i = 0; i < 1200 && k < 3; i++) begin
      @(negedge clk); #1;
      if (k >= 1 && g_m[0].touching !== 1'b1) bad++;
      if (g_m[0].valid) begin
        t[k] = cyc;
        ex = exp_x.pop_front(); ey = exp_y.pop_front();
        if (g_m[0].xa !== ex || g_m[0].ya !== ey || g_m[0].touching !== 1'b1) bad_val++;
        k++;
      end
    end
    irq[0] = 1'b1;
    n_checks++; if (k !== 3) $display("FAIL cont_count: got %0d valids expected 3", k); else n_pass++;
    n_checks++; if (bad_val !== 0) $display("FAIL cont_values: got %0d bad reports expected 0", bad_val); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL cont_touching: got %0d low cycles expected 0", bad); else n_pass++;
    if (k == 3) begin
      n_checks++; if (t[1] - t[0] !== 195 + GAP + 1)
        $display("FAIL cont_spacing_1: got %0d expected %0d", t[1] - t[0], 195 + GAP + 1); else n_pass++;
      n_checks++; if (t[2] - t[1] !== 195 + GAP + 1)
        $display("FAIL cont_spacing_2: got %0d expected %0d", t[2] - t[1], 195 + GAP + 1); else n_pass++;
    end
    repeat (300) @(negedge clk);
  endtask

  task automatic test_pen_lift();
    logic [11:0] ex, ey;
    longint t_v, t_up;
    int r0, cs_low;
    bit seen;
    exp_x.delete(); exp_y.delete();
    xs[0][0] = 'h777; ys[0][0] = 'h001;
    exp_x.push_back(12'h777); exp_y.push_back(12'h001);
    @(negedge clk); #1;
    irq[0] = 1'b0;
    for (int i = 0; i < 20 && g_m[0].cs; i++) begin @(negedge clk); #1; end
    repeat (40) @(negedge clk);
    #1;
    irq[0] = 1'b1;
    seen = 0; t_v = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (g_m[0].valid) begin
        seen = 1; t_v = cyc;
        ex = exp_x.pop_front(); ey = exp_y.pop_front();
        n_checks++; if ({g_m[0].xa, g_m[0].ya} !== {ex, ey})
          $display("FAIL lift_values: got %h expected %h", {g_m[0].xa, g_m[0].ya}, {ex, ey}); else n_pass++;
        break;
      end
    end
    n_checks++; if (!seen) $display("FAIL lift_valid: got no valid expected one"); else n_pass++;
    t_up = 0;
    for (int i = 0; i < 50 && g_m[0].touching; i++) begin @(negedge clk); #1; t_up = cyc; end
    n_checks++; if (t_up - t_v !== GAP + 1)
      $display("FAIL lift_touch_release: got %0d cycles expected %0d", t_up - t_v, GAP + 1); else n_pass++;
    r0 = g_m[0].rises;
    cs_low = 0;
    repeat (300) begin @(negedge clk); #1; if (!g_m[0].cs) cs_low++; end
    n_checks++; if (g_m[0].rises - r0 !== 0)
      $display("FAIL lift_dclk_quiet: got %0d rises expected 0", g_m[0].rises - r0); else n_pass++;
    n_checks++; if (cs_low !== 0) $display("FAIL lift_cs_high: got %0d low cycles expected 0", cs_low); else n_pass++;
  endtask

  task automatic test_average();
    logic [11:0] ex, ey;
    int c0;
    bit seen;
    exp_x.delete(); exp_y.delete();
    for (int i = 0; i < 4; i++) begin xs[1][i] = 100 + i; ys[1][i] = 4095; end
    exp_x.push_back(12'd101); exp_y.push_back(12'd4095);
    c0 = g_m[1].ncmd;
    @(negedge clk); #1;
    irq[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (g_m[1].valid) begin
        seen = 1;
        irq[1] = 1'b1;
        ex = exp_x.pop_front(); ey = exp_y.pop_front();
        n_checks++; if (g_m[1].xa !== ex) $display("FAIL avg_x: got %0d expected %0d", g_m[1].xa, ex); else n_pass++;
        n_checks++; if (g_m[1].ya !== ey) $display("FAIL avg_y: got %0d expected %0d", g_m[1].ya, ey); else n_pass++;
        n_checks++; if (cyc - g_m[1].csfall !== 771)
          $display("FAIL avg_latency: got %0d expected 771", cyc - g_m[1].csfall); else n_pass++;
        break;
      end
    end
    irq[1] = 1'b1;
    n_checks++; if (!seen) $display("FAIL avg_valid: got no valid expected one"); else n_pass++;
    n_checks++; if (g_m[1].ncmd - c0 !== 8)
      $display("FAIL avg_frames: got %0d commands expected 8", g_m[1].ncmd - c0); else n_pass++;
    n_checks++; if ({g_m[1].cmd_log[(c0 + 3) % 64], g_m[1].cmd_log[(c0 + 4) % 64]} !== 16'hD090)
      $display("FAIL avg_axis_order: got %h expected d090", {g_m[1].cmd_log[(c0 + 3) % 64], g_m[1].cmd_log[(c0 + 4) % 64]}); else n_pass++;
    repeat (100) @(negedge clk);
  endtask

  task automatic test_8bit();
    logic [11:0] ex, ey;
    int c0;
    bit seen;
    exp_x.delete(); exp_y.delete();
    xs[2][0] = 'h5A; ys[2][0] = 'hC3;
    exp_x.push_back(12'h05A); exp_y.push_back(12'h0C3);
    c0 = g_m[2].ncmd;
    @(negedge clk); #1;
    irq[2] = 1'b0;
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (g_m[2].valid) begin
        seen = 1;
        irq[2] = 1'b1;
        ex = exp_x.pop_front(); ey = exp_y.pop_front();
        n_checks++; if ({4'd0, g_m[2].xa} !== ex) $display("FAIL b8_x: got %h expected %h", g_m[2].xa, ex); else n_pass++;
        n_checks++; if ({4'd0, g_m[2].ya} !== ey) $display("FAIL b8_y: got %h expected %h", g_m[2].ya, ey); else n_pass++;
        break;
      end
    end
    irq[2] = 1'b1;
    n_checks++; if (!seen) $display("FAIL b8_valid: got no valid expected one"); else n_pass++;
    n_checks++; if (g_m[2].cmd_log[c0 % 64] !== 8'hD8)
      $display("FAIL b8_cmd_x: got %h expected d8", g_m[2].cmd_log[c0 % 64]); else n_pass++;
    n_checks++; if (g_m[2].cmd_log[(c0 + 1) % 64] !== 8'h98)
      $display("FAIL b8_cmd_y: got %h expected 98", g_m[2].cmd_log[(c0 + 1) % 64]); else n_pass++;
    repeat (100) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      irq[i] = 1'b1;
      for (int j = 0; j < 4; j++) begin xs[i][j] = 0; ys[i][j] = 0; end
    end
    test_reset();
    test_single();
    test_continuous();
    test_pen_lift();
    test_average();
    test_8bit();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
